rgb_pwm_fader: RTL

- Downstream stage of the per-channel RGB register block.
- Takes a 24-bit target colour (R/G/B bytes), ramps each channel linearly from its current level toward the target at a programmable rate, and drives the three PWM bits into the SB_RGBA_DRV PWM inputs.
- Replaces the bare per-channel PWM so that colour changes written over Wishbone appear as glitch-free fades.

---
 rtl/rgb_pkg.sv | 17 +
 rtl/rgb_pwm_channel.sv | 87 ++++++++
 rtl/rgb_pwm_fader.sv | 98 +++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared constants for the RGB PWM fader: default resolution, channel indices
// and byte-lane placement of each channel inside the packed colour word.
package rgb_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int NUM_CH       = 3;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // LSB position of a channel's lane in the packed {B,G,R} colour word
    function automatic int lane_lsb(input int ch, input int bits);
        return ch * bits;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One colour channel: target/current level, +/-1 fade stepping, period-aligned
// duty shadow and a registered compare against the shared PWM counter.
module rgb_pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                target_stb,
    input  logic [PWM_BITS-1:0] target_in,
    input  logic                jump,
    input  logic                tick,
    input  logic                period_end,
    input  logic                en_rise,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] cur,
    output logic                neq,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] LVL_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS-1:0] r_cur;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;
    logic [PWM_BITS-1:0] w_cur_next;
    logic [PWM_BITS-1:0] w_duty_eff;

    // Next level: a strobe always wins over a step; compare-before-step prevents wrap
    always_comb begin
        w_cur_next = r_cur;
        if (!enable) begin
            w_cur_next = r_cur;
        end else if (target_stb) begin
            w_cur_next = jump ? target_in : r_cur;
        end else if (jump) begin
            w_cur_next = r_target;
        end else if (tick && (r_cur < r_target)) begin
            w_cur_next = r_cur + LVL_ONE;
        end else if (tick && (r_cur > r_target)) begin
            w_cur_next = r_cur - LVL_ONE;
        end else begin
            w_cur_next = r_cur;
        end
    end

    // Target and current level registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_target <= {PWM_BITS{1'b0}};
            r_cur    <= {PWM_BITS{1'b0}};
        end else begin
            if (enable && target_stb) begin
                r_target <= target_in;
            end else begin
                r_target <= r_target;
            end
            r_cur <= w_cur_next;
        end
    end

    // On the enable edge the shadow is still stale, so compare against cur directly
    assign w_duty_eff = en_rise ? r_cur : r_duty;

    // Duty shadow and registered PWM compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_duty <= {PWM_BITS{1'b0}};
            r_pwm  <= 1'b0;
        end else begin
            if (period_end || en_rise) begin
                r_duty <= r_cur;
            end else begin
                r_duty <= r_duty;
            end
            r_pwm <= enable & (pwm_cnt < w_duty_eff);
        end
    end

    assign cur = r_cur;
    assign neq = (r_cur != r_target);
    assign pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB fader top: shared PWM counter, fade-rate prescaler, enable-edge detect
// and busy aggregation around three rgb_pwm_channel instances.
module rgb_pwm_fader
    import rgb_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [3*PWM_BITS-1:0]   target_rgb,
    input  logic                    target_stb,
    input  logic [PRESCALE_W-1:0]   fade_step,
    output logic [3*PWM_BITS-1:0]   cur_rgb,
    output logic                    busy,
    output logic [2:0]              pwm_o
);

    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0]   CNT_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_enable_d;

    logic [PRESCALE_W-1:0] w_presc_last;
    logic                  w_jump;
    logic                  w_tick;
    logic                  w_period_end;
    logic                  w_en_rise;
    logic [NUM_CH-1:0]     w_neq;
    logic [NUM_CH-1:0]     w_pwm;

    assign w_jump       = (fade_step == {PRESCALE_W{1'b0}});
    assign w_presc_last = fade_step - PRE_ONE;
    // >= rather than == so a mid-fade shrink of fade_step cannot strand the count
    assign w_tick       = enable & busy & ~target_stb & ~w_jump & (r_presc >= w_presc_last);
    assign w_period_end = enable & (r_pwm_cnt == {PWM_BITS{1'b1}});
    assign w_en_rise    = enable & ~r_enable_d;

    // Free-running PWM counter, parked at 0 while disabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
        end else if (!enable) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + CNT_ONE;
        end
    end

    // Fade prescaler: frozen while disabled, cleared when idle, on strobe or on tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= {PRESCALE_W{1'b0}};
        end else if (!enable) begin
            r_presc <= r_presc;
        end else if (target_stb || !busy || w_tick) begin
            r_presc <= {PRESCALE_W{1'b0}};
        end else begin
            r_presc <= r_presc + PRE_ONE;
        end
    end

    // Enable edge detector
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_enable_d <= 1'b0;
        end else begin
            r_enable_d <= enable;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .target_stb (target_stb),
            .target_in  (target_rgb[lane_lsb(ch, PWM_BITS) +: PWM_BITS]),
            .jump       (w_jump),
            .tick       (w_tick),
            .period_end (w_period_end),
            .en_rise    (w_en_rise),
            .pwm_cnt    (r_pwm_cnt),
            .cur        (cur_rgb[lane_lsb(ch, PWM_BITS) +: PWM_BITS]),
            .neq        (w_neq[ch]),
            .pwm        (w_pwm[ch])
        );
    end

    assign busy  = |w_neq;
    assign pwm_o = {w_pwm[CH_B], w_pwm[CH_G], w_pwm[CH_R]};

endmodule
